parity_frame_checker: RTL
=========================

PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the number of data bits per frame (legal range 1..32).
REQ-002 The block SHALL have parameter ODD_PAR, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 Port clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 Port rst  input  1  is the reset, asynchronous and active-high.
REQ-005 Port x  input  1  is the serial bit, sampled only when in_valid=1.
REQ-006 Port in_valid  input  1  qualifies x; a bit is accepted on each clk edge with in_valid=1.
REQ-007 Port frame_start  input  1  marks x as the first data bit of a frame; it is meaningful only with in_valid=1.
REQ-008 Port err_clr  input  1  clears err_count synchronously.
REQ-009 Port data_out  output  DATA_W  is the deserialized frame data, LSB received first.
REQ-010 Port out_valid  output  1  is a one-cycle pulse that qualifies data_out and parity_err.
REQ-011 Port parity_err  output  1  is set when the received parity bit mismatches; it is valid only with out_valid.
REQ-012 Port frame_abort  output  1  is a one-cycle pulse indicating that an unfinished frame was discarded.
REQ-013 Port busy  output  1  is 1 whenever the state is not IDLE.
REQ-014 Port err_count  output  16  is a saturating count of frames with parity_err=1.

Function
REQ-015 The FSM SHALL have states IDLE, DATA, and PARITY.
REQ-016 IDLE: an accepted bit with frame_start=1 SHALL load bit 0, set running parity p=x, set bit index=1, and go to DATA (or to PARITY if DATA_W=1).
REQ-017 IDLE: an accepted bit with frame_start=0 SHALL be discarded with no output.
REQ-018 DATA: each accepted bit SHALL be stored at the current index, XORed into p, and increment the index; after bit DATA_W-1 the FSM SHALL go to PARITY.
REQ-019 PARITY: the accepted bit is the parity bit; the error SHALL be p^x for even parity and ~(p^x) for odd parity; the FSM SHALL return to IDLE.
REQ-020 out_valid SHALL pulse in the cycle after the parity bit is accepted, with data_out and parity_err registered; this is 1 cycle of latency.
REQ-021 data_out SHALL hold its value until the next out_valid.
REQ-022 When in_valid=0, the FSM, index, and p SHALL hold; stalls of any length SHALL NOT alter the result.
REQ-023 frame_start=1 with an accepted bit in DATA or PARITY SHALL pulse frame_abort in the next cycle, discard the partial frame, and restart as in REQ-016 using that bit; no out_valid is produced for the discarded frame.
REQ-024 err_count SHALL increment on each out_valid with parity_err=1 and saturate at 16'hFFFF.
REQ-025 If err_clr coincides with an increment, err_clr SHALL win and the result SHALL be 0.
REQ-026 The index SHALL be $clog2(DATA_W+1) bits wide and SHALL never exceed DATA_W-1 in DATA.

Reset
REQ-027 rst=1 SHALL asynchronously force the state to IDLE, p=0, index=0, data_out=0, out_valid=0, parity_err=0, frame_abort=0, busy=0, and err_count=0.
REQ-028 rst asserted mid-frame SHALL drop the frame with no out_valid and no frame_abort; the first accepted bit after release requires frame_start.

Structure
REQ-029 Package parity_pkg SHALL hold the FSM state enum (IDLE/DATA/PARITY) and the constants PAR_EVEN=1'b0 and PAR_ODD=1'b1.
REQ-030 The saturating 16-bit error counter with clear SHALL be the sub-module parity_err_counter; everything else SHALL be in parity_frame_checker.

Verification
REQ-031 Good frame: DATA_W=8, even parity; frame_start plus bits of 0xA5 LSB-first, then parity 0 -> out_valid one cycle after the parity bit, data_out=0xA5, parity_err=0, err_count=0.
REQ-032 Bad frame: same frame with parity 1 -> parity_err=1 and err_count=1; the same frame with ODD_PAR=1 and parity 1 -> parity_err=0.
REQ-033 Stall: 0x3C with in_valid low for 3 cycles after bit 4 -> data_out=0x3C, parity_err=0, out_valid exactly once.
REQ-034 Abort: frame_start re-asserted at bit 5, followed by a full 0xFF frame with parity 0 -> frame_abort pulse the next cycle, then data_out=0xFF, parity_err=0.
REQ-035 Clear and collision: err_count=2, then err_clr asserted in the same cycle as a bad-frame out_valid -> err_count=0.
REQ-036 Reset mid-frame: rst pulsed between clk edges at bit 3 -> all outputs 0 immediately; no out_valid follows until a new frame_start frame completes.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity frame checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned ERR_CNT_W = 16;

endpackage

// File: rtl/parity_err_counter.sv
// Saturating error counter with a synchronous clear that overrides increment.
module parity_err_counter
  import parity_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [ERR_CNT_W-1:0] count
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [ERR_CNT_W-1:0] count_q;
  logic [ERR_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/parity_frame_checker.sv
// Deserializes LSB-first frames of DATA_W bits followed by a parity bit and
// reports the frame with its parity status; frame_start mid-frame restarts.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ODD_PAR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x,
  input  logic                 in_valid,
  input  logic                 frame_start,
  input  logic                 err_clr,
  output logic [DATA_W-1:0]    data_out,
  output logic                 out_valid,
  output logic                 parity_err,
  output logic                 frame_abort,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned     IDX_W    = $clog2(DATA_W + 1);
  localparam logic            PAR_SEL  = (ODD_PAR != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                p_q, p_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                out_valid_q, out_valid_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_abort_q, frame_abort_d;
  logic                busy_q, busy_d;

  // Next-state and output decode; nothing moves unless a bit is accepted.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    p_d           = p_q;
    asm_d         = asm_q;
    data_out_d    = data_out_q;
    parity_err_d  = parity_err_q;
    out_valid_d   = 1'b0;
    frame_abort_d = 1'b0;

    if (in_valid) begin
      if (frame_start) begin
        // A start inside a frame discards the partial frame and reuses this bit.
        frame_abort_d = (state_q != IDLE);
        asm_d         = '0;
        asm_d[0]      = x;
        p_d           = x;
        idx_d         = IDX_W'(1);
        state_d       = (DATA_W == 1) ? PARITY : DATA;
      end else begin
        case (state_q)
          IDLE: begin
          end
          DATA: begin
            for (int i = 0; i < int'(DATA_W); i++) begin
              if (idx_q == IDX_W'(i)) begin
                asm_d[i] = x;
              end
            end
            p_d   = p_q ^ x;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              state_d = PARITY;
            end
          end
          PARITY: begin
            out_valid_d  = 1'b1;
            data_out_d   = asm_q;
            parity_err_d = p_q ^ x ^ PAR_SEL;
            idx_d        = '0;
            p_d          = 1'b0;
            state_d      = IDLE;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      p_q           <= 1'b0;
      asm_q         <= '0;
      data_out_q    <= '0;
      out_valid_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      p_q           <= p_d;
      asm_q         <= asm_d;
      data_out_q    <= data_out_d;
      out_valid_q   <= out_valid_d;
      parity_err_q  <= parity_err_d;
      frame_abort_q <= frame_abort_d;
      busy_q        <= busy_d;
    end
  end

  parity_err_counter u_err_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid_q & parity_err_q),
    .clr   (err_clr),
    .count (err_count)
  );

  assign data_out    = data_out_q;
  assign out_valid   = out_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_abort = frame_abort_q;
  assign busy        = busy_q;

endmodule
